// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Central sequencer for the 3-stage core (pc_reg -> if_id -> id_ex
//            -> ex). Arbitrates stall and jump requests, drives per-stage
//            hold/bubble flags and the redirect to pc_reg, defers a jump that
//            arrives during a stall, stretches jump flushes over fetch latency
//            and keeps stall statistics plus a sticky stall watchdog.
// Ports    : clk, rst_n           clock, synchronous active-low reset
//            jump_flag_i/addr_i   EX redirect request (single-cycle pulse)
//            ex/bus/id_stall_i    stall requests (levels)
//            timeout_clr_i        clears stall_timeout_o
//            jump_flag_o/addr_o   redirect strobe and target to pc_reg
//            hold_pc/if/id_o      freeze PC / bubble if_id / bubble id_ex
//            stall_timeout_o      sticky watchdog flag
//            stall_cycles_o       free-running count of PC-frozen cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 255,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              ex_stall_i,
  input  logic              bus_stall_i,
  input  logic              id_stall_i,
  input  logic              timeout_clr_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              hold_pc_o,
  output logic              hold_if_o,
  output logic              hold_id_o,
  output logic              stall_timeout_o,
  output logic [31:0]       stall_cycles_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // The issuing cycle is itself the first flush cycle, so FLUSH covers the rest.
  localparam logic [2:0]  C_FLUSH_LOAD  = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] C_TIMEOUT_VAL = 16'(STALL_TIMEOUT);

  state_e              state_q, state_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic [15:0]         consec_q, consec_d;
  logic                timeout_q, timeout_d;
  logic [31:0]         stall_cycles_q, stall_cycles_d;

  logic                w_big_stall;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_issue_addr;
  logic                w_hold_pc;
  logic                w_hold_if;
  logic                w_hold_id;

  assign w_big_stall = ex_stall_i | bus_stall_i;

  // --------------------------------------------------------------------------
  // Next-state and output logic. RUN and the cycle a stall drops share the
  // same decision tree, so a stall release re-evaluates jump/ID inputs at once.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    flush_cnt_d  = flush_cnt_q;
    w_issue      = 1'b0;
    w_issue_addr = '0;
    w_hold_pc    = 1'b0;
    w_hold_if    = 1'b0;
    w_hold_id    = 1'b0;

    if (w_big_stall) begin
      // Whole pipe frozen; any remaining flush is moot. A jump seen now is
      // parked and the newest one wins.
      w_hold_pc   = 1'b1;
      w_hold_if   = 1'b1;
      w_hold_id   = 1'b1;
      flush_cnt_d = '0;
      state_d     = ST_STALL;
      if (jump_flag_i) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = jump_addr_i;
      end
    end else if (pend_valid_q) begin
      // Deferred jump goes first; a simultaneous new jump is parked behind it.
      w_issue      = 1'b1;
      w_issue_addr = pend_addr_q;
      pend_valid_d = jump_flag_i;
      if (jump_flag_i) begin
        pend_addr_d = jump_addr_i;
      end
    end else if (jump_flag_i) begin
      w_issue      = 1'b1;
      w_issue_addr = jump_addr_i;
    end else if (state_q == ST_FLUSH) begin
      // id_stall_i deliberately ignored: the bubbled ID slot holds no hazard.
      w_hold_if   = 1'b1;
      w_hold_id   = 1'b1;
      flush_cnt_d = flush_cnt_q - 3'd1;
      if (flush_cnt_q <= 3'd1) begin
        state_d = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
      if (id_stall_i) begin
        w_hold_pc = 1'b1;
        w_hold_if = 1'b1;
      end
    end

    if (w_issue) begin
      w_hold_if = 1'b1;
      w_hold_id = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        flush_cnt_d = C_FLUSH_LOAD;
        state_d     = ST_FLUSH;
      end else begin
        flush_cnt_d = '0;
        state_d     = ST_RUN;
      end
    end
  end

  // Outputs forced quiet while reset is held so the pipe sees no stray strobe.
  assign jump_flag_o = rst_n & w_issue;
  assign jump_addr_o = (rst_n & w_issue) ? w_issue_addr : '0;
  assign hold_pc_o   = rst_n & w_hold_pc;
  assign hold_if_o   = rst_n & w_hold_if;
  assign hold_id_o   = rst_n & w_hold_id;

  // --------------------------------------------------------------------------
  // Statistics and watchdog
  // --------------------------------------------------------------------------
  always_comb begin
    consec_d = '0;
    if (w_big_stall) begin
      consec_d = (consec_q == C_TIMEOUT_VAL) ? consec_q : consec_q + 16'd1;
    end
    // Setting has priority over clearing, so a stall still at the limit
    // keeps the flag asserted.
    if (consec_d == C_TIMEOUT_VAL) begin
      timeout_d = 1'b1;
    end else if (timeout_clr_i) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
    stall_cycles_d = stall_cycles_q + {31'd0, hold_pc_o};
  end

  assign stall_timeout_o = timeout_q;
  assign stall_cycles_o  = stall_cycles_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pend_valid_q   <= 1'b0;
      pend_addr_q    <= '0;
      flush_cnt_q    <= '0;
      consec_q       <= '0;
      timeout_q      <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      pend_valid_q   <= pend_valid_d;
      pend_addr_q    <= pend_addr_d;
      flush_cnt_q    <= flush_cnt_d;
      consec_q       <= consec_d;
      timeout_q      <= timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl (FLUSH_CYCLES=3,
//            STALL_TIMEOUT=255). Each cycle's stimulus and expected outputs
//            are pushed to a scoreboard; a negedge checker pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        ex_stall_i;
  logic        bus_stall_i;
  logic        id_stall_i;
  logic        timeout_clr_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        hold_if_o;
  logic        hold_id_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;

  pipe_ctrl #(
    .FLUSH_CYCLES (3),
    .STALL_TIMEOUT(255),
    .ADDR_W       (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jump_flag_i    (jump_flag_i),
    .jump_addr_i    (jump_addr_i),
    .ex_stall_i     (ex_stall_i),
    .bus_stall_i    (bus_stall_i),
    .id_stall_i     (id_stall_i),
    .timeout_clr_i  (timeout_clr_i),
    .jump_flag_o    (jump_flag_o),
    .jump_addr_o    (jump_addr_o),
    .hold_pc_o      (hold_pc_o),
    .hold_if_o      (hold_if_o),
    .hold_id_o      (hold_id_o),
    .stall_timeout_o(stall_timeout_o),
    .stall_cycles_o (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [95:0] name;
    logic        rst_n;
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  stl;   // {ex, bus, id}
    logic        clr;
    logic        ejf;
    logic [31:0] eja;
    logic [2:0]  ehold; // {pc, if, id}
    logic        eto;
    logic [31:0] esc;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(input logic [95:0] name, input logic r, input logic jf,
                              input logic [31:0] ja, input logic [2:0] stl, input logic clr,
                              input logic ejf, input logic [31:0] eja, input logic [2:0] ehold,
                              input logic eto, input logic [31:0] esc);
    vec_t v;
    v.name = name; v.rst_n = r; v.jf = jf; v.ja = ja; v.stl = stl; v.clr = clr;
    v.ejf = ejf; v.eja = eja; v.ehold = ehold; v.eto = eto; v.esc = esc;
    return v;
  endfunction

  task automatic step(input vec_t v);
    rst_n         = v.rst_n;
    jump_flag_i   = v.jf;
    jump_addr_i   = v.ja;
    ex_stall_i    = v.stl[2];
    bus_stall_i   = v.stl[1];
    id_stall_i    = v.stl[0];
    timeout_clr_i = v.clr;
    sb.push_back(v);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard checker: outputs are settled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      logic ok;
      e  = sb.pop_front();
      ok = (jump_flag_o == e.ejf) &&
           (!e.ejf || jump_addr_o == e.eja) &&
           ({hold_pc_o, hold_if_o, hold_id_o} == e.ehold) &&
           (stall_timeout_o == e.eto) &&
           (stall_cycles_o == e.esc);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got jf=%b ja=%h hold=%b to=%b sc=%0d, want jf=%b ja=%h hold=%b to=%b sc=%0d",
                 e.name, jump_flag_o, jump_addr_o, {hold_pc_o, hold_if_o, hold_id_o},
                 stall_timeout_o, stall_cycles_o, e.ejf, e.eja, e.ehold, e.eto, e.esc);
      end
    end
  end

  initial begin
    rst_n = 1'b0; jump_flag_i = 1'b0; jump_addr_i = '0;
    ex_stall_i = 1'b0; bus_stall_i = 1'b0; id_stall_i = 1'b0; timeout_clr_i = 1'b0;
    @(posedge clk);
    #1;

    //            name         rst jf ja         {e,b,i} clr ejf eja     hold    to sc
    tbl.push_back(mk("reset",    0, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    tbl.push_back(mk("reset",    0, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("idle",   1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    // jump in RUN, flush stretched over 3 cycles
    tbl.push_back(mk("jmp_iss",  1, 1, 32'h100, 3'b000, 0, 1, 32'h100, 3'b011, 0, 0));
    tbl.push_back(mk("jmp_fl1",  1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 0));
    tbl.push_back(mk("jmp_fl2",  1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 0));
    tbl.push_back(mk("jmp_end",  1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    // ex stall with deferred jump
    tbl.push_back(mk("exs_1",    1, 0, 32'h0,   3'b100, 0, 0, 32'h0,   3'b111, 0, 0));
    tbl.push_back(mk("exs_2j",   1, 1, 32'h200, 3'b100, 0, 0, 32'h0,   3'b111, 0, 1));
    tbl.push_back(mk("exs_3",    1, 0, 32'h0,   3'b100, 0, 0, 32'h0,   3'b111, 0, 2));
    tbl.push_back(mk("exs_4",    1, 0, 32'h0,   3'b100, 0, 0, 32'h0,   3'b111, 0, 3));
    tbl.push_back(mk("defer_is", 1, 0, 32'h0,   3'b000, 0, 1, 32'h200, 3'b011, 0, 4));
    tbl.push_back(mk("defer_f1", 1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 4));
    tbl.push_back(mk("defer_f2", 1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 4));
    tbl.push_back(mk("defer_end",1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 4));
    // id stall coincident with jump; id stall ignored during flush
    tbl.push_back(mk("idj_iss",  1, 1, 32'h300, 3'b001, 0, 1, 32'h300, 3'b011, 0, 4));
    tbl.push_back(mk("idj_f1",   1, 0, 32'h0,   3'b001, 0, 0, 32'h0,   3'b011, 0, 4));
    tbl.push_back(mk("idj_f2",   1, 0, 32'h0,   3'b001, 0, 0, 32'h0,   3'b011, 0, 4));
    tbl.push_back(mk("id_run",   1, 0, 32'h0,   3'b001, 0, 0, 32'h0,   3'b110, 0, 4));
    tbl.push_back(mk("id_done",  1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 5));
    // new jump inside FLUSH reloads the counter
    tbl.push_back(mk("rl_iss",   1, 1, 32'h400, 3'b000, 0, 1, 32'h400, 3'b011, 0, 5));
    tbl.push_back(mk("rl_f1",    1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 5));
    tbl.push_back(mk("rl_iss2",  1, 1, 32'h500, 3'b000, 0, 1, 32'h500, 3'b011, 0, 5));
    tbl.push_back(mk("rl_f1b",   1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 5));
    tbl.push_back(mk("rl_f2b",   1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 5));
    tbl.push_back(mk("rl_end",   1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 5));
    // bus stall abandons a flush
    tbl.push_back(mk("ab_iss",   1, 1, 32'h600, 3'b000, 0, 1, 32'h600, 3'b011, 0, 5));
    tbl.push_back(mk("ab_bus",   1, 0, 32'h0,   3'b010, 0, 0, 32'h0,   3'b111, 0, 5));
    tbl.push_back(mk("ab_run",   1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 6));
    // jump together with big stall in RUN is deferred
    tbl.push_back(mk("cj_bus",   1, 1, 32'h700, 3'b010, 0, 0, 32'h0,   3'b111, 0, 6));
    tbl.push_back(mk("cj_iss",   1, 0, 32'h0,   3'b000, 0, 1, 32'h700, 3'b011, 0, 7));
    tbl.push_back(mk("cj_f1",    1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 7));
    tbl.push_back(mk("cj_f2",    1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b011, 0, 7));
    tbl.push_back(mk("cj_end",   1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 7));
    // stall release evaluates id stall the same cycle
    tbl.push_back(mk("rel_ex",   1, 0, 32'h0,   3'b100, 0, 0, 32'h0,   3'b111, 0, 7));
    tbl.push_back(mk("rel_id",   1, 0, 32'h0,   3'b001, 0, 0, 32'h0,   3'b110, 0, 8));
    tbl.push_back(mk("rel_end",  1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 9));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Watchdog: 255 consecutive bus-stall cycles, flag sticky until cleared.
    for (int i = 0; i < 255; i++)
      step(mk("to_stall", 1, 0, 32'h0, 3'b010, 0, 0, 32'h0, 3'b111, 0, 32'(9 + i)));
    step(mk("to_set",   1, 0, 32'h0, 3'b000, 0, 0, 32'h0, 3'b000, 1, 264));
    step(mk("to_stick", 1, 0, 32'h0, 3'b000, 0, 0, 32'h0, 3'b000, 1, 264));
    step(mk("to_clr",   1, 0, 32'h0, 3'b000, 1, 0, 32'h0, 3'b000, 1, 264));
    step(mk("to_clred", 1, 0, 32'h0, 3'b000, 0, 0, 32'h0, 3'b000, 0, 264));

    // Reset with a deferred jump parked: it must never issue.
    step(mk("rp_iss",   1, 1, 32'h800, 3'b000, 0, 1, 32'h800, 3'b011, 0, 264));
    step(mk("rp_park",  1, 1, 32'h900, 3'b100, 0, 0, 32'h0,   3'b111, 0, 264));
    step(mk("rp_rst",   0, 0, 32'h0,   3'b100, 0, 0, 32'h0,   3'b000, 0, 265));
    step(mk("rp_post1", 1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    step(mk("rp_post2", 1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    step(mk("rp_post3", 1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    // Reset in the middle of a flush ends it.
    step(mk("rf_iss",   1, 1, 32'hA00, 3'b000, 0, 1, 32'hA00, 3'b011, 0, 0));
    step(mk("rf_rst",   0, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    step(mk("rf_post1", 1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));
    step(mk("rf_post2", 1, 0, 32'h0,   3'b000, 0, 0, 32'h0,   3'b000, 0, 0));

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
